sram_load_ctrl: RTL and testbench

- Downstream consumer of the clock-gating stage.
- Runs on the gated clock. On the one-cycle start_in pulse it accepts a stream of DEPTH data words over a valid/ready handshake and writes them to consecutive SRAM addresses from 0.
- After the last write completes it issues a one-cycle clk_end pulse back to the clock gate, which closes the clock.

---
 rtl/sram_load_ctrl.sv | 133 +++++++++++++
 tb/tb_sram_load_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_load_ctrl.sv
// Loads DEPTH words from a valid/ready stream into SRAM addresses 0..DEPTH-1, then pulses clk_end.
// Optional idle timeout with sticky err is enabled by defining LOAD_TIMEOUT_EN.
module sram_load_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  din_ready,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  busy,
    output logic                  clk_end,
    output logic                  err
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH counts to the end without wrapping.
    localparam int unsigned CntW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    wr_n_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    accept;
    logic                    last;
    logic                    timeout;

    assign accept = (state_q == StLoad) && din_valid;
    assign last   = (cnt_q == CntW'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = StDrain;
                    end
                end else if (timeout) begin
                    state_d = StDone;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_n_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_n_q  <= ~accept;
            // Address and data hold between writes; only the enables toggle.
            if (accept) begin
                addr_q  <= cnt_q[ADDR_WIDTH-1:0];
                wdata_q <= din;
            end
        end
    end

`ifdef LOAD_TIMEOUT_EN
    localparam int unsigned IdleW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [IdleW-1:0] idle_q;
    logic             err_q;

    // Fires on the TIMEOUT-th consecutive cycle without acceptance.
    assign timeout = !accept && (idle_q == IdleW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else if (state_q == StIdle) begin
            idle_q <= '0;
            if (start_in) begin
                err_q <= 1'b0;
            end
        end else if (state_q == StLoad) begin
            if (accept) begin
                idle_q <= '0;
            end else if (timeout) begin
                idle_q <= '0;
                err_q  <= 1'b1;
            end else begin
                idle_q <= idle_q + 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

    assign din_ready  = (state_q == StLoad);
    assign busy       = (state_q != StIdle);
    assign clk_end    = (state_q == StDone);
    assign sram_cen   = wr_n_q;
    assign sram_wen   = wr_n_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_load_ctrl.sv
// Scoreboard bench for sram_load_ctrl with DEPTH=4; define LOAD_TIMEOUT_EN to add the timeout case.
module tb_sram_load_ctrl;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic          clk_i = 1'b0;
    logic          rst;
    logic          start_in;
    logic          din_valid;
    logic [DW-1:0] din;
    logic          din_ready;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          busy;
    logic          clk_end;
    logic          err;

    int total = 0;
    int bad   = 0;
    int ends  = 0;
    int sent  = 0;
    bit in_load = 1'b0;
    logic [AW+DW-1:0] exp_q[$];

    sram_load_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i     (clk_i),
        .rst       (rst),
        .start_in  (start_in),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .busy      (busy),
        .clk_end   (clk_end),
        .err       (err)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        in_load  = 1'b1;
        sent     = 0;
    endtask

    // One LOAD cycle: expected write is queued only if the model says the word is taken.
    task automatic drive(input bit v, input logic [DW-1:0] d);
        din_valid = v;
        din       = d;
        chk("ready", 64'(din_ready), 64'(in_load));
        chk("busy", 64'(busy), 64'd1);
        if (v && in_load) begin
            exp_q.push_back({AW'(sent), d});
            sent++;
            if (sent == int'(DEPTH)) in_load = 1'b0;
        end
        step();
        din_valid = 1'b0;
        din       = '0;
    endtask

    // Called in the DRAIN cycle; optionally pokes start_in during DONE.
    task automatic finish_load(input bit poke);
        chk("drain_ready", 64'(din_ready), 64'd0);
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_end", 64'(clk_end), 64'd0);
        step();
        chk("done_end", 64'(clk_end), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        start_in = poke;
        step();
        start_in = 1'b0;
        chk("idle_end", 64'(clk_end), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready", 64'(din_ready), 64'd0);
        step();
        chk("idle2_busy", 64'(busy), 64'd0);
        chk("idle2_ready", 64'(din_ready), 64'd0);
        chk("err_clear", 64'(err), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(din_ready), 64'd0);
        chk({tag, "_cen"}, 64'(sram_cen), 64'd1);
        chk({tag, "_wen"}, 64'(sram_wen), 64'd1);
        chk({tag, "_addr"}, 64'(sram_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(sram_wdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_end"}, 64'(clk_end), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    always @(negedge clk_i) begin
        if (rst === 1'b1) begin
            if (clk_end === 1'b1) ends++;
            if (sram_cen === 1'b0) begin
                chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
                chk("wr_wen", 64'(sram_wen), 64'd0);
                if (exp_q.size() != 0) begin
                    chk("wr_addr_data", 64'({sram_addr, sram_wdata}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int e0;
        int n;

        rst       = 1'b0;
        start_in  = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b1;

        // Idle: din_valid without start_in is ignored.
        din_valid = 1'b1;
        din       = 32'hFF;
        for (int i = 0; i < 10; i++) begin
            chk("idle_ready", 64'(din_ready), 64'd0);
            chk("idle_cen", 64'(sram_cen), 64'd1);
            chk("idle_busy", 64'(busy), 64'd0);
            step();
        end
        din_valid = 1'b0;
        chk("idle_no_end", 64'(ends), 64'd0);

        // Back-to-back stream, start_in poked during DONE.
        e0 = ends;
        pulse_start();
        for (int i = 0; i < int'(DEPTH); i++) drive(1'b1, 32'hA0 + i);
        finish_load(1'b1);
        chk("stream_ends", 64'(ends - e0), 64'd1);

        // Gapped valid pattern.
        e0 = ends;
        n  = 0;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            if (pat[i]) begin
                drive(1'b1, 32'hB0 + n);
                n++;
            end else begin
                drive(1'b0, 32'hDEAD);
            end
        end
        finish_load(1'b0);
        chk("gap_ends", 64'(ends - e0), 64'd1);

        // start_in during LOAD is ignored.
        e0 = ends;
        pulse_start();
        drive(1'b1, 32'hC0);
        drive(1'b1, 32'hC1);
        start_in = 1'b1;
        drive(1'b0, 32'h0);
        start_in = 1'b0;
        drive(1'b1, 32'hC2);
        drive(1'b1, 32'hC3);
        finish_load(1'b0);
        chk("restart_ends", 64'(ends - e0), 64'd1);

        // Reset mid-load, then a fresh load restarts at address 0.
        pulse_start();
        drive(1'b1, 32'hD0);
        drive(1'b1, 32'hD1);
        drive(1'b0, 32'h0);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        chk("midrst_queue", 64'(exp_q.size()), 64'd0);
        in_load = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("post_rst_busy", 64'(busy), 64'd0);
        e0 = ends;
        pulse_start();
        for (int i = 0; i < int'(DEPTH); i++) drive(1'b1, 32'hE0 + i);
        finish_load(1'b0);
        chk("post_rst_ends", 64'(ends - e0), 64'd1);

`ifdef LOAD_TIMEOUT_EN
        // One word, then silence: timeout after TIMEOUT idle cycles.
        e0 = ends;
        pulse_start();
        drive(1'b1, 32'hF0);
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            chk("to_wait_end", 64'(clk_end), 64'd0);
            chk("to_wait_err", 64'(err), 64'd0);
            step();
        end
        chk("to_end", 64'(clk_end), 64'd1);
        chk("to_err", 64'(err), 64'd1);
        in_load = 1'b0;
        step();
        chk("to_idle_busy", 64'(busy), 64'd0);
        chk("to_err_sticky", 64'(err), 64'd1);
        chk("to_ends", 64'(ends - e0), 64'd1);
        chk("to_queue", 64'(exp_q.size()), 64'd0);
        pulse_start();
        chk("to_err_cleared", 64'(err), 64'd0);
        for (int i = 0; i < int'(DEPTH); i++) drive(1'b1, 32'h50 + i);
        finish_load(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
